alpide_dctrl_responder: RTL and testbench
=========================================

Name: alpide_dctrl_responder

Overview:
- Slave end of the ALPIDE DCTRL control link; emulates the chip-side control port.
- Deserialises opcode/chipid/address/data characters, issues register write/read strobes to a local register model, and serialises the 3-character read reply on the shared line.
- Used in the chip emulator and loop-back benches, where it sits opposite the DAQ control master.

Parameters:
- OP_WR, 8'h9C, write opcode.
- OP_RD, 8'h4E, read opcode.
- RESP_GAP, 17, idle bit periods between sampling the last request stop bit and driving the first reply start bit. Reply start bit lands in bit slot 57, where the opcode start bit is slot 0.
- ERRW, 16, width of the framing-error counter.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous reset, active low.
- phase_i  in  1  one-cycle bit-period strobe, at most every 2nd cycle.
- chipid_i  in  8  this chip's ID.
- dctrl_i  in  1  resolved DCTRL line; idle/undriven reads 1.
- dctrl_o  out  1  serial reply data.
- dctrl_oe_o  out  1  line drive enable.
- cmd_valid_o  out  1  one-cycle pulse: broadcast command received.
- cmd_opcode_o  out  8  opcode of last command.
- reg_we_o  out  1  one-cycle write strobe.
- reg_re_o  out  1  one-cycle read strobe.
- reg_addr_o  out  16  register address.
- reg_wdata_o  out  16  write data.
- reg_rdata_i  in  16  read data; sampled RESP_GAP strobes after reg_re_o.
- busy_o  out  1  FSM not IDLE.
- frame_err_o  out  ERRW  saturating count of bad stop bits.

Behaviour:
- Sampling and drive timing:
  - dctrl_i is sampled only on clock edges with phase_i=1.
  - dctrl_o and dctrl_oe_o change only on those edges.
- Character format: 10 bits = start 0, 8 data bits LSB first, stop 1. Characters are back-to-back with no gaps.
- Request order: opcode, chipid, addr[7:0], addr[15:8], data[7:0], data[15:8]. Write uses 6 characters, read uses 4, a command uses 1.
- States: IDLE, RX, GAP, TX.
- IDLE: a sampled 0 starts a character; go to RX with bit count 1 and char index 0.
- RX: shift in 8 data bits, then check the stop bit.
  - Stop bit 0: increment frame_err_o (saturates at all-ones), abandon the frame, return to IDLE. No strobes are issued.
  - Stop bit OK after char 0, opcode not OP_WR/OP_RD: pulse cmd_valid_o one cycle after the stop sample, latch cmd_opcode_o, return to IDLE.
  - Stop bit OK, otherwise: wait for the next start bit. A sampled 1 where a start bit is expected is a framing error.
- Chip ID match: set match when the chipid char equals chipid_i. On a mismatch the frame is still fully tracked, including GAP/TX timing, but no strobes are issued and OE stays 0 (listen-only).
- Write: after the char-5 stop bit, if matched, pulse reg_we_o one cycle with reg_addr_o/reg_wdata_o valid. Return to IDLE.
- Read: after the char-3 stop bit, if matched, pulse reg_re_o with reg_addr_o valid, then enter GAP.
- GAP: count RESP_GAP strobes. On the last one, latch reg_rdata_i and enter TX.
- TX: 30 bits = chipid_i char, rdata[7:0] char, rdata[15:8] char, same character format.
  - dctrl_oe_o=1 only across these 30 bit periods, and only if matched.
  - After bit 30: OE=0, dctrl_o=1, go to IDLE.
  - dctrl_i is ignored in GAP and TX.
- Reset values: dctrl_o=1, dctrl_oe_o=0, all strobes 0, cmd_opcode_o=0, reg_addr_o=0, reg_wdata_o=0, frame_err_o=0, state IDLE. Asserting reset mid-TX releases OE asynchronously.
- phase_i held low: all state freezes, no timeout.

Optional Feature:
- Macro: DCTRL_BCAST_EN.
- When defined: chipid 8'h0F also matches for writes, so reg_we_o pulses. A read to 8'h0F is tracked listen-only (no reg_re_o, no drive), so multiple responders never contend.
- When undefined: 8'h0F matches only if chipid_i==8'h0F.

Test Plan:
- Command: send opcode 8'hD2 -> one cmd_valid_o pulse, cmd_opcode_o=8'hD2, no reg strobes, frame_err_o=0.
- Write: chipid_i=8'h10, send 9C,10,34,12,CD,AB -> single reg_we_o with reg_addr_o=16'h1234, reg_wdata_o=16'hABCD; dctrl_oe_o stays 0.
- Read: chipid_i=8'h10, rdata=16'hBEEF, send 4E,10,05,00 -> reg_re_o with addr 16'h0005. Line is then idle for 17 bits. Reply bits on dctrl_o = 0,10h LSB-first,1, 0,EFh,1, 0,BEh,1. OE high for exactly 30 strobes.
- Mismatch read: send 4E,22,05,00 with chipid_i=8'h10 -> no reg_re_o, OE never asserted. Responder returns to IDLE after 4*10+17+30 strobes and accepts the next frame.
- Framing error: corrupt the stop bit of char 2 in a write -> frame_err_o=1, no reg_we_o. The next valid write succeeds.
- Reset: assert rst_ni low mid-TX -> dctrl_oe_o=0 and dctrl_o=1 immediately, without waiting for a clock edge. Broadcast: write to chipid 8'h0F -> reg_we_o only with DCTRL_BCAST_EN defined.

Source files
------------

// File: rtl/alpide_dctrl_responder.sv
// rtl/alpide_dctrl_responder.sv - chip-side ALPIDE DCTRL control port: request deserialiser, register strobes, read reply.
// Optional DCTRL_BCAST_EN: chipid 8'h0F also matches writes; reads to 8'h0F are tracked listen-only.
module alpide_dctrl_responder #(
    parameter logic [7:0] OP_WR    = 8'h9C,
    parameter logic [7:0] OP_RD    = 8'h4E,
    parameter int         RESP_GAP = 17,
    parameter int         ERRW     = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            phase_i,
    input  logic [7:0]      chipid_i,
    input  logic            dctrl_i,
    output logic            dctrl_o,
    output logic            dctrl_oe_o,
    output logic            cmd_valid_o,
    output logic [7:0]      cmd_opcode_o,
    output logic            reg_we_o,
    output logic            reg_re_o,
    output logic [15:0]     reg_addr_o,
    output logic [15:0]     reg_wdata_o,
    input  logic [15:0]     reg_rdata_i,
    output logic            busy_o,
    output logic [ERRW-1:0] frame_err_o
);

    localparam int GW = (RESP_GAP > 1) ? $clog2(RESP_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(RESP_GAP - 1);
`ifdef DCTRL_BCAST_EN
    localparam logic [7:0] BCAST_ID = 8'h0F;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RX, S_GAP, S_TX} state_t;

    state_t          state_q, state_d;
    logic [3:0]      bit_cnt_q;
    logic [2:0]      char_idx_q;
    logic [7:0]      sh_q;
    logic [7:0]      opcode_q;
    logic            match_q;
    logic [7:0]      addr_lo_q;
    logic [15:0]     addr_q;
    logic [7:0]      wdata_lo_q;
    logic [GW-1:0]   gap_cnt_q;
    logic [29:0]     tx_sr_q;
    logic [4:0]      tx_cnt_q;

    logic start_rx, ferr, char_ok, cmd_evt, we_evt, re_evt, gap_go, tx_done;
    logic id_match;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_rx = 1'b0;
        ferr     = 1'b0;
        char_ok  = 1'b0;
        cmd_evt  = 1'b0;
        we_evt   = 1'b0;
        re_evt   = 1'b0;
        gap_go   = 1'b0;
        tx_done  = 1'b0;
        if (phase_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!dctrl_i) begin
                        start_rx = 1'b1;
                        state_d  = S_RX;
                    end
                end
                S_RX: begin
                    // bit_cnt 0 means a start bit is due; 9 is the stop bit
                    if (bit_cnt_q == 4'd0) begin
                        if (dctrl_i) begin
                            ferr    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (bit_cnt_q == 4'd9) begin
                        if (!dctrl_i) begin
                            ferr    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            char_ok = 1'b1;
                            case (char_idx_q)
                                3'd0: begin
                                    if (sh_q != OP_WR && sh_q != OP_RD) begin
                                        cmd_evt = 1'b1;
                                        state_d = S_IDLE;
                                    end
                                end
                                3'd3: begin
                                    if (opcode_q == OP_RD) begin
                                        re_evt  = 1'b1;
                                        state_d = S_GAP;
                                    end
                                end
                                3'd5: begin
                                    we_evt  = 1'b1;
                                    state_d = S_IDLE;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_go  = 1'b1;
                        state_d = S_TX;
                    end
                end
                S_TX: begin
                    if (tx_cnt_q == 5'd29) begin
                        tx_done = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        id_match = (sh_q == chipid_i);
`ifdef DCTRL_BCAST_EN
        if (sh_q == BCAST_ID)
            id_match = (opcode_q == OP_WR);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt_q    <= 4'd0;
            char_idx_q   <= 3'd0;
            sh_q         <= 8'd0;
            opcode_q     <= 8'd0;
            match_q      <= 1'b0;
            addr_lo_q    <= 8'd0;
            addr_q       <= 16'd0;
            wdata_lo_q   <= 8'd0;
            gap_cnt_q    <= '0;
            tx_sr_q      <= '1;
            tx_cnt_q     <= 5'd0;
            dctrl_o      <= 1'b1;
            dctrl_oe_o   <= 1'b0;
            cmd_valid_o  <= 1'b0;
            cmd_opcode_o <= 8'd0;
            reg_we_o     <= 1'b0;
            reg_re_o     <= 1'b0;
            reg_addr_o   <= 16'd0;
            reg_wdata_o  <= 16'd0;
            frame_err_o  <= '0;
        end else begin
            cmd_valid_o <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            if (phase_i) begin
                if (start_rx) begin
                    bit_cnt_q  <= 4'd1;
                    char_idx_q <= 3'd0;
                    match_q    <= 1'b0;
                end
                if (state_q == S_RX) begin
                    if (bit_cnt_q == 4'd0) begin
                        if (!dctrl_i) begin
                            bit_cnt_q  <= 4'd1;
                            char_idx_q <= char_idx_q + 3'd1;
                        end
                    end else if (bit_cnt_q != 4'd9) begin
                        sh_q      <= {dctrl_i, sh_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                if (char_ok) begin
                    bit_cnt_q <= 4'd0;
                    case (char_idx_q)
                        3'd0:    opcode_q   <= sh_q;
                        3'd1:    match_q    <= id_match;
                        3'd2:    addr_lo_q  <= sh_q;
                        3'd3:    addr_q     <= {sh_q, addr_lo_q};
                        3'd4:    wdata_lo_q <= sh_q;
                        default: ;
                    endcase
                end
                if (ferr && frame_err_o != {ERRW{1'b1}})
                    frame_err_o <= frame_err_o + ERRW'(1);
                if (cmd_evt) begin
                    cmd_valid_o  <= 1'b1;
                    cmd_opcode_o <= sh_q;
                end
                if (re_evt) begin
                    gap_cnt_q <= '0;
                    if (match_q) begin
                        reg_re_o   <= 1'b1;
                        reg_addr_o <= {sh_q, addr_lo_q};
                    end
                end
                if (we_evt && match_q) begin
                    reg_we_o    <= 1'b1;
                    reg_addr_o  <= addr_q;
                    reg_wdata_o <= {sh_q, wdata_lo_q};
                end
                if (state_q == S_GAP)
                    gap_cnt_q <= gap_cnt_q + GW'(1);
                // start bit goes out on the last gap strobe so the master samples it one slot later
                if (gap_go) begin
                    tx_sr_q  <= {1'b1, 1'b1, reg_rdata_i[15:8], 1'b0, 1'b1,
                                 reg_rdata_i[7:0], 1'b0, 1'b1, chipid_i};
                    tx_cnt_q <= 5'd0;
                    if (match_q) begin
                        dctrl_o    <= 1'b0;
                        dctrl_oe_o <= 1'b1;
                    end
                end
                if (state_q == S_TX) begin
                    tx_sr_q  <= {1'b1, tx_sr_q[29:1]};
                    tx_cnt_q <= tx_cnt_q + 5'd1;
                    if (tx_done) begin
                        dctrl_o    <= 1'b1;
                        dctrl_oe_o <= 1'b0;
                    end else if (match_q) begin
                        dctrl_o <= tx_sr_q[0];
                    end
                end
            end
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_alpide_dctrl_responder.sv
// tb/tb_alpide_dctrl_responder.sv - directed-vector bench for alpide_dctrl_responder.
module tb_alpide_dctrl_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        phase_i = 1'b0;
    logic [7:0]  chipid_i = 8'h10;
    logic        dctrl_i = 1'b1;
    logic        dctrl_o;
    logic        dctrl_oe_o;
    logic        cmd_valid_o;
    logic [7:0]  cmd_opcode_o;
    logic        reg_we_o;
    logic        reg_re_o;
    logic [15:0] reg_addr_o;
    logic [15:0] reg_wdata_o;
    logic [15:0] reg_rdata_i = 16'hBEEF;
    logic        busy_o;
    logic [15:0] frame_err_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    int we_cnt = 0, re_cnt = 0, cmd_cnt = 0, oe_cnt = 0;
    logic [15:0] we_addr, we_data, re_addr;
    logic obs_o, obs_oe, obs_busy;

    alpide_dctrl_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .phase_i(phase_i), .chipid_i(chipid_i),
        .dctrl_i(dctrl_i), .dctrl_o(dctrl_o), .dctrl_oe_o(dctrl_oe_o),
        .cmd_valid_o(cmd_valid_o), .cmd_opcode_o(cmd_opcode_o),
        .reg_we_o(reg_we_o), .reg_re_o(reg_re_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i),
        .busy_o(busy_o), .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (reg_we_o) begin we_cnt++; we_addr = reg_addr_o; we_data = reg_wdata_o; end
        if (reg_re_o) begin re_cnt++; re_addr = reg_addr_o; end
        if (cmd_valid_o) cmd_cnt++;
        if (dctrl_oe_o) oe_cnt++;
    end

    // one bit period: strobe cycle then a quiet cycle; outputs sampled at the negedge after the strobe
    task automatic tick(input logic b);
        @(negedge clk_i);
        dctrl_i = b;
        phase_i = 1'b1;
        @(posedge clk_i);
        #1 phase_i = 1'b0;
        @(negedge clk_i);
        obs_o = dctrl_o;
        obs_oe = dctrl_oe_o;
        obs_busy = busy_o;
    endtask

    task automatic send_char(input logic [7:0] c, input logic stop);
        tick(1'b0);
        for (int i = 0; i < 8; i++) tick(c[i]);
        tick(stop);
    endtask

    task automatic send_write(input logic [7:0] id, input logic [15:0] a, input logic [15:0] d);
        send_char(8'h9C, 1'b1);
        send_char(id, 1'b1);
        send_char(a[7:0], 1'b1);
        send_char(a[15:8], 1'b1);
        send_char(d[7:0], 1'b1);
        send_char(d[15:8], 1'b1);
    endtask

    task automatic test_reset;
        vec_cnt++;
        if ({dctrl_o, dctrl_oe_o, busy_o} !== 3'b100) begin
            err_cnt++; $display("FAIL reset_line o/oe/busy got %b want 100", {dctrl_o, dctrl_oe_o, busy_o});
        end
        vec_cnt++;
        if ({cmd_opcode_o, reg_addr_o, reg_wdata_o, frame_err_o} !== 56'd0) begin
            err_cnt++; $display("FAIL reset_regs got %h want 0", {cmd_opcode_o, reg_addr_o, reg_wdata_o, frame_err_o});
        end
    endtask

    task automatic test_command;
        int c0, w0, r0;
        c0 = cmd_cnt; w0 = we_cnt; r0 = re_cnt;
        send_char(8'hD2, 1'b1);
        tick(1'b1);
        vec_cnt++;
        if (cmd_cnt - c0 !== 1) begin err_cnt++; $display("FAIL cmd_pulses got %0d want 1", cmd_cnt - c0); end
        vec_cnt++;
        if (cmd_opcode_o !== 8'hD2) begin err_cnt++; $display("FAIL cmd_opcode got %h want d2", cmd_opcode_o); end
        vec_cnt++;
        if ((we_cnt - w0) + (re_cnt - r0) !== 0 || frame_err_o !== 16'd0 || busy_o !== 1'b0) begin
            err_cnt++; $display("FAIL cmd_side_effects we/re %0d/%0d ferr %0d busy %b want 0/0 0 0",
                                we_cnt - w0, re_cnt - r0, frame_err_o, busy_o);
        end
    endtask

    task automatic test_write;
        int w0, o0;
        w0 = we_cnt; o0 = oe_cnt;
        send_write(8'h10, 16'h1234, 16'hABCD);
        tick(1'b1);
        vec_cnt++;
        if (we_cnt - w0 !== 1) begin err_cnt++; $display("FAIL write_pulses got %0d want 1", we_cnt - w0); end
        vec_cnt++;
        if (we_addr !== 16'h1234 || we_data !== 16'hABCD) begin
            err_cnt++; $display("FAIL write_addr_data got %h/%h want 1234/abcd", we_addr, we_data);
        end
        vec_cnt++;
        if (oe_cnt !== o0) begin err_cnt++; $display("FAIL write_oe cycles got %0d want 0", oe_cnt - o0); end
    endtask

    task automatic test_read;
        logic [29:0] exp_bits, got_bits;
        int r0, n_oe, first_oe, idx;
        exp_bits = {1'b1, 8'hBE, 1'b0, 1'b1, 8'hEF, 1'b0, 1'b1, 8'h10, 1'b0};
        got_bits = '1;
        r0 = re_cnt; n_oe = 0; first_oe = -1; idx = 0;
        send_char(8'h4E, 1'b1);
        send_char(8'h10, 1'b1);
        send_char(8'h05, 1'b1);
        send_char(8'h00, 1'b1);
        for (int s = 40; s <= 86; s++) begin
            tick(1'b1);
            if (obs_oe) begin
                if (first_oe < 0) first_oe = s;
                n_oe++;
                if (idx < 30) got_bits[idx] = obs_o;
                idx++;
            end
            if (s == 85 && obs_busy !== 1'b1) begin
                vec_cnt++; err_cnt++; $display("FAIL read_busy_tx got %b want 1", obs_busy);
            end
        end
        vec_cnt++;
        if (re_cnt - r0 !== 1 || re_addr !== 16'h0005) begin
            err_cnt++; $display("FAIL read_strobe got %0d addr %h want 1 addr 0005", re_cnt - r0, re_addr);
        end
        vec_cnt++;
        if (first_oe !== 56 || n_oe !== 30) begin
            err_cnt++; $display("FAIL read_oe_window first %0d count %0d want 56 30", first_oe, n_oe);
        end
        vec_cnt++;
        if (got_bits !== exp_bits) begin
            err_cnt++; $display("FAIL read_reply_bits got %b want %b", got_bits, exp_bits);
        end
        vec_cnt++;
        if ({obs_o, obs_oe, obs_busy} !== 3'b100) begin
            err_cnt++; $display("FAIL read_end o/oe/busy got %b want 100", {obs_o, obs_oe, obs_busy});
        end
    endtask

    task automatic test_mismatch_read;
        int r0, o0, w0;
        logic busy85, busy86;
        r0 = re_cnt; o0 = oe_cnt; w0 = we_cnt;
        send_char(8'h4E, 1'b1);
        send_char(8'h22, 1'b1);
        send_char(8'h05, 1'b1);
        send_char(8'h00, 1'b1);
        busy85 = 1'b0; busy86 = 1'b1;
        for (int s = 40; s <= 86; s++) begin
            tick(1'b1);
            if (s == 85) busy85 = obs_busy;
            if (s == 86) busy86 = obs_busy;
        end
        vec_cnt++;
        if (re_cnt !== r0 || oe_cnt !== o0) begin
            err_cnt++; $display("FAIL mismatch_silent re %0d oe %0d want 0 0", re_cnt - r0, oe_cnt - o0);
        end
        vec_cnt++;
        if (busy85 !== 1'b1 || busy86 !== 1'b0) begin
            err_cnt++; $display("FAIL mismatch_length busy@85 %b busy@86 %b want 1 0", busy85, busy86);
        end
        send_write(8'h10, 16'h0077, 16'h00AA);
        tick(1'b1);
        vec_cnt++;
        if (we_cnt - w0 !== 1 || we_addr !== 16'h0077 || we_data !== 16'h00AA) begin
            err_cnt++; $display("FAIL mismatch_next_frame we %0d %h/%h want 1 0077/00aa", we_cnt - w0, we_addr, we_data);
        end
    endtask

    task automatic test_frame_err;
        int w0, c0;
        w0 = we_cnt; c0 = cmd_cnt;
        send_char(8'h9C, 1'b1);
        send_char(8'h10, 1'b1);
        send_char(8'h34, 1'b0);
        repeat (4) tick(1'b1);
        vec_cnt++;
        if (frame_err_o !== 16'd1 || we_cnt !== w0 || busy_o !== 1'b0) begin
            err_cnt++; $display("FAIL ferr_stop cnt %0d we %0d busy %b want 1 0 0", frame_err_o, we_cnt - w0, busy_o);
        end
        send_write(8'h10, 16'h5678, 16'h1122);
        tick(1'b1);
        vec_cnt++;
        if (we_cnt - w0 !== 1 || we_addr !== 16'h5678 || we_data !== 16'h1122) begin
            err_cnt++; $display("FAIL ferr_recover we %0d %h/%h want 1 5678/1122", we_cnt - w0, we_addr, we_data);
        end
        send_char(8'h4E, 1'b1);
        repeat (3) tick(1'b1);
        vec_cnt++;
        if (frame_err_o !== 16'd2 || cmd_cnt !== c0) begin
            err_cnt++; $display("FAIL ferr_missing_start cnt %0d cmd %0d want 2 0", frame_err_o, cmd_cnt - c0);
        end
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = cmd_cnt;
        send_char(8'hA5, 1'b1);
        send_char(8'h3C, 1'b1);
        tick(1'b1);
        vec_cnt++;
        if (cmd_cnt - c0 !== 2 || cmd_opcode_o !== 8'h3C) begin
            err_cnt++; $display("FAIL b2b_cmds count %0d op %h want 2 3c", cmd_cnt - c0, cmd_opcode_o);
        end
    endtask

    task automatic test_phase_freeze;
        int w0;
        logic [7:0] op;
        w0 = we_cnt;
        op = 8'h9C;
        tick(1'b0);
        for (int i = 0; i < 4; i++) tick(op[i]);
        repeat (40) @(negedge clk_i);
        vec_cnt++;
        if (busy_o !== 1'b1 || frame_err_o !== 16'd2) begin
            err_cnt++; $display("FAIL freeze_hold busy %b ferr %0d want 1 2", busy_o, frame_err_o);
        end
        for (int i = 4; i < 8; i++) tick(op[i]);
        tick(1'b1);
        send_char(8'h10, 1'b1);
        send_char(8'h42, 1'b1);
        send_char(8'h00, 1'b1);
        send_char(8'h5A, 1'b1);
        send_char(8'hA5, 1'b1);
        tick(1'b1);
        vec_cnt++;
        if (we_cnt - w0 !== 1 || we_addr !== 16'h0042 || we_data !== 16'hA55A) begin
            err_cnt++; $display("FAIL freeze_resume we %0d %h/%h want 1 0042/a55a", we_cnt - w0, we_addr, we_data);
        end
    endtask

    task automatic test_reset_mid_tx;
        send_char(8'h4E, 1'b1);
        send_char(8'h10, 1'b1);
        send_char(8'h01, 1'b1);
        send_char(8'h00, 1'b1);
        for (int s = 40; s <= 65; s++) tick(1'b1);
        vec_cnt++;
        if (obs_oe !== 1'b1) begin err_cnt++; $display("FAIL rst_pre_tx oe got %b want 1", obs_oe); end
        #2 rst_ni = 1'b0;
        #1;
        vec_cnt++;
        if ({dctrl_o, dctrl_oe_o, busy_o} !== 3'b100) begin
            err_cnt++; $display("FAIL rst_async o/oe/busy got %b want 100", {dctrl_o, dctrl_oe_o, busy_o});
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick(1'b1);
    endtask

    task automatic test_bcast;
        int w0, r0, o0, exp_we;
        w0 = we_cnt; r0 = re_cnt; o0 = oe_cnt;
`ifdef DCTRL_BCAST_EN
        exp_we = 1;
`else
        exp_we = 0;
`endif
        send_write(8'h0F, 16'h00F0, 16'h0F0F);
        tick(1'b1);
        vec_cnt++;
        if (we_cnt - w0 !== exp_we) begin
            err_cnt++; $display("FAIL bcast_write we %0d want %0d", we_cnt - w0, exp_we);
        end
        send_char(8'h4E, 1'b1);
        send_char(8'h0F, 1'b1);
        send_char(8'h01, 1'b1);
        send_char(8'h00, 1'b1);
        for (int s = 40; s <= 87; s++) tick(1'b1);
        vec_cnt++;
        if (re_cnt !== r0 || oe_cnt !== o0 || busy_o !== 1'b0) begin
            err_cnt++; $display("FAIL bcast_read re %0d oe %0d busy %b want 0 0 0", re_cnt - r0, oe_cnt - o0, busy_o);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        test_reset;
        test_command;
        test_write;
        test_read;
        test_mismatch_read;
        test_frame_err;
        test_back_to_back;
        test_phase_freeze;
        test_reset_mid_tx;
        test_bcast;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
